// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2c_pkg
// Description : Shared types and constants for the I2C register-file slave.
//               Holds the protocol state enumeration and the R/W and ACK
//               bit encodings used on the wire.
// Revision    : 1.0 - initial release
// ============================================================================
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_PTR       = 4'd3,
        ST_PTR_ACK   = 4'd4,
        ST_WDATA     = 4'd5,
        ST_WDATA_ACK = 4'd6,
        ST_RDATA     = 4'd7,
        ST_RDATA_ACK = 4'd8
    } i2c_slv_state_t;

    localparam logic I2C_RW_WRITE = 1'b0;
    localparam logic I2C_RW_READ  = 1'b1;
    localparam logic I2C_ACK      = 1'b0;
    localparam logic I2C_NACK     = 1'b1;

endpackage : i2c_pkg
`default_nettype wire

// File: rtl/i2c_line_sync.sv
`default_nettype none
// ============================================================================
// Module      : i2c_line_sync
// Description : Two-flop synchroniser for SCL/SDA followed by a previous-
//               sample register; decodes SCL edges and START/STOP.
// Ports       : clk, reset_n     - system clock, async active-low reset
//               scl, sda         - raw bus lines
//               scl_rise/scl_fall- one-cycle SCL edge pulses
//               start_det        - SDA fell while SCL high
//               stop_det         - SDA rose while SCL high
//               sda_s            - synchronised SDA level
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_line_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic scl,
    input  logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    logic [1:0] scl_sync_q;
    logic [1:0] sda_sync_q;
    logic       scl_prev_q;
    logic       sda_prev_q;
    logic [1:0] settle_q;
    logic       scl_s;
    logic       live;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // Bus idles high, so resetting to 1 avoids phantom edges.
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            settle_q   <= 2'd0;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl};
            sda_sync_q <= {sda_sync_q[0], sda};
            scl_prev_q <= scl_sync_q[1];
            sda_prev_q <= sda_sync_q[1];
            if (settle_q != 2'd3) begin
                settle_q <= settle_q + 2'd1;
            end
        end
    end

    // Decoding is held off until the pipeline holds real bus samples, so a
    // reset released mid-transfer cannot fabricate a START from stale 1s.
    assign live      = (settle_q == 2'd3);
    assign scl_s     = scl_sync_q[1];
    assign sda_s     = sda_sync_q[1];
    assign scl_rise  = live &  scl_s & ~scl_prev_q;
    assign scl_fall  = live & ~scl_s &  scl_prev_q;
    assign start_det = live & scl_s & scl_prev_q &  sda_prev_q & ~sda_s;
    assign stop_det  = live & scl_s & scl_prev_q & ~sda_prev_q &  sda_s;

endmodule : i2c_line_sync
`default_nettype wire

// File: rtl/i2c_slave_regfile.sv
`default_nettype none
// ============================================================================
// Module      : i2c_slave_regfile
// Description : I2C slave with an auto-incrementing byte register bank. The
//               first written byte selects the register pointer; following
//               bytes are written or read with wrap at NUM_REGS.
// Ports       : clk, reset_n         - system clock, async active-low reset
//               scl, sda             - I2C bus (sda open-drain)
//               loc_we/addr/wdata    - local register write port
//               regs                 - flattened register bank
//               wr_strobe/rd_strobe  - I2C write / read-load pulses
//               acc_addr             - register index of the last strobe
//               busy                 - slave addressed, transfer ongoing
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_slave_regfile
    import i2c_pkg::*;
#(
    parameter logic [6:0] ADDRESS  = 7'h50,
    parameter int         NUM_REGS = 16,
    parameter int         PTR_W    = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  scl,
    inout  wire                   sda,
    input  logic                  loc_we,
    input  logic [PTR_W-1:0]      loc_addr,
    input  logic [7:0]            loc_wdata,
    output logic [NUM_REGS*8-1:0] regs,
    output logic                  wr_strobe,
    output logic                  rd_strobe,
    output logic [PTR_W-1:0]      acc_addr,
    output logic                  busy
);

    logic scl_rise, scl_fall, start_det, stop_det, sda_s;

    i2c_line_sync u_sync (
        .clk       (clk),
        .reset_n   (reset_n),
        .scl       (scl),
        .sda       (sda),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_s     (sda_s)
    );

    i2c_slv_state_t   state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             rw_q, rw_d;
    logic             sda_oe_q, sda_oe_d;
    logic             busy_q, busy_d;
    logic [PTR_W-1:0] acc_addr_q, acc_addr_d;
    logic             wr_strobe_q, wr_strobe_d;
    logic             rd_strobe_q, rd_strobe_d;

    logic [7:0]       regs_q [NUM_REGS];
    logic [7:0]       rx_byte;
    logic [7:0]       rd_byte;
    logic             i2c_we;
    logic             load_rd;
    logic             ptr_ok;

    assign rx_byte = {shift_q[6:0], sda_s};
    assign rd_byte = regs_q[ptr_q];
    assign ptr_ok  = ({1'b0, rx_byte} < 9'(NUM_REGS));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'd0;
            ptr_q       <= '0;
            rw_q        <= I2C_RW_WRITE;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            acc_addr_q  <= '0;
            wr_strobe_q <= 1'b0;
            rd_strobe_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            ptr_q       <= ptr_d;
            rw_q        <= rw_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            acc_addr_q  <= acc_addr_d;
            wr_strobe_q <= wr_strobe_d;
            rd_strobe_q <= rd_strobe_d;
        end
    end

    // Register bank: the I2C write is applied last so it wins a same-index
    // collision with the local port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= 8'd0;
            end
        end else begin
            if (loc_we) begin
                regs_q[loc_addr] <= loc_wdata;
            end
            if (i2c_we) begin
                regs_q[ptr_q] <= rx_byte;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        ptr_d       = ptr_q;
        rw_d        = rw_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        acc_addr_d  = acc_addr_q;
        wr_strobe_d = 1'b0;
        rd_strobe_d = 1'b0;
        i2c_we      = 1'b0;
        load_rd     = 1'b0;

        if (stop_det) begin
            state_d  = ST_IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (start_det) begin
            // busy is kept across a repeated START until the address decides.
            state_d   = ST_ADDR;
            bit_cnt_d = 3'd0;
            sda_oe_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                end
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (rx_byte[7:1] == ADDRESS) begin
                                state_d = ST_ADDR_ACK;
                                rw_d    = rx_byte[0];
                                busy_d  = 1'b1;
                            end else begin
                                state_d = ST_IDLE;
                                busy_d  = 1'b0;
                            end
                        end
                    end
                end
                // ACK phases: the first SCL fall starts driving 0, the
                // second SCL fall (after the master sampled it) ends it.
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else if (rw_q == I2C_RW_WRITE) begin
                            state_d   = ST_PTR;
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 3'd0;
                        end else begin
                            load_rd = 1'b1;
                        end
                    end
                end
                ST_PTR: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (ptr_ok) begin
                                ptr_d   = rx_byte[PTR_W-1:0];
                                state_d = ST_PTR_ACK;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end
                    end
                end
                ST_PTR_ACK, ST_WDATA_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            state_d   = ST_WDATA;
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 3'd0;
                        end
                    end
                end
                ST_WDATA: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            i2c_we      = 1'b1;
                            wr_strobe_d = 1'b1;
                            acc_addr_d  = ptr_q;
                            ptr_d       = ptr_q + PTR_W'(1);
                            state_d     = ST_WDATA_ACK;
                        end
                    end
                end
                // bit_cnt counts bits already presented; the fall after the
                // 8th bit hands the line to the master for its ACK.
                ST_RDATA: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 3'd7) begin
                            sda_oe_d  = 1'b0;
                            ptr_d     = ptr_q + PTR_W'(1);
                            bit_cnt_d = 3'd0;
                            state_d   = ST_RDATA_ACK;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                            shift_d   = {shift_q[6:0], 1'b0};
                            sda_oe_d  = ~shift_q[6];
                        end
                    end
                end
                // bit_cnt=1 marks "master ACKed"; the next byte is loaded on
                // the following SCL fall so the line only changes with SCL low.
                ST_RDATA_ACK: begin
                    if (scl_rise) begin
                        if (sda_s == I2C_ACK) begin
                            bit_cnt_d = 3'd1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else if (scl_fall && (bit_cnt_q == 3'd1)) begin
                        load_rd = 1'b1;
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end

        if (load_rd) begin
            state_d     = ST_RDATA;
            shift_d     = rd_byte;
            sda_oe_d    = ~rd_byte[7];
            rd_strobe_d = 1'b1;
            acc_addr_d  = ptr_q;
            bit_cnt_d   = 3'd0;
        end
    end

    assign sda       = sda_oe_q ? 1'b0 : 1'bz;
    assign wr_strobe = wr_strobe_q;
    assign rd_strobe = rd_strobe_q;
    assign acc_addr  = acc_addr_q;
    assign busy      = busy_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs[8*g +: 8] = regs_q[g];
    end

endmodule : i2c_slave_regfile
`default_nettype wire

// File: tb/tb_i2c_slave_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_slave_regfile
// Description : Self-checking bench for i2c_slave_regfile: bit-banged I2C
//               master, a second slave at 0x51 on the same bus, and an
//               array-based model of the register bank and pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_slave_regfile;

    localparam int         NR = 16;
    localparam int         Q  = 50;
    localparam logic [6:0] A0 = 7'h50;
    localparam logic [6:0] A1 = 7'h51;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n  = 1'b0;
    logic          scl_m    = 1'b1;
    logic          sda_m_low = 1'b0;
    logic          loc_we   = 1'b0;
    logic [3:0]    loc_addr = 4'd0;
    logic [7:0]    loc_wdata = 8'd0;
    logic          zero_we  = 1'b0;
    logic [3:0]    zero_a   = 4'd0;
    logic [7:0]    zero_d   = 8'd0;

    wire sda_bus;
    pullup (sda_bus);
    assign sda_bus = sda_m_low ? 1'b0 : 1'bz;

    logic [NR*8-1:0] regs0, regs1;
    logic            wr0, rd0, busy0, wr1, rd1, busy1;
    logic [3:0]      acc0, acc1;

    i2c_slave_regfile #(.ADDRESS(A0), .NUM_REGS(NR)) u_dut (
        .clk(clk), .reset_n(reset_n), .scl(scl_m), .sda(sda_bus),
        .loc_we(loc_we), .loc_addr(loc_addr), .loc_wdata(loc_wdata),
        .regs(regs0), .wr_strobe(wr0), .rd_strobe(rd0),
        .acc_addr(acc0), .busy(busy0)
    );

    i2c_slave_regfile #(.ADDRESS(A1), .NUM_REGS(NR)) u_other (
        .clk(clk), .reset_n(reset_n), .scl(scl_m), .sda(sda_bus),
        .loc_we(zero_we), .loc_addr(zero_a), .loc_wdata(zero_d),
        .regs(regs1), .wr_strobe(wr1), .rd_strobe(rd1),
        .acc_addr(acc1), .busy(busy1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] mregs [NR];
    int         mptr;

    logic [3:0] wr_q[$];
    logic [3:0] rd_q[$];
    logic       busy_seen;

    always @(negedge clk) begin
        if (wr0) wr_q.push_back(acc0);
        if (rd0) rd_q.push_back(acc0);
        if (busy0) busy_seen = 1'b1;
    end

    function automatic logic [NR*8-1:0] model_flat();
        logic [NR*8-1:0] r;
        for (int i = 0; i < NR; i++) r[8*i +: 8] = mregs[i];
        return r;
    endfunction

    task automatic model_write(input int p, input logic [7:0] d [8], input int n);
        for (int k = 0; k < n; k++) mregs[(p + k) % NR] = d[k];
        mptr = (p + n) % NR;
    endtask

    task automatic model_clear();
        for (int i = 0; i < NR; i++) mregs[i] = 8'd0;
        mptr = 0;
    endtask

    // ---------------- bit-banged master ----------------
    task automatic m_start();
        sda_m_low = 1'b0; #Q;
        scl_m = 1'b1;     #Q;
        sda_m_low = 1'b1; #Q;
        scl_m = 1'b0;     #Q;
    endtask

    task automatic m_stop();
        sda_m_low = 1'b1; #Q;
        scl_m = 1'b1;     #Q;
        sda_m_low = 1'b0; #Q;
    endtask

    task automatic m_send(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            sda_m_low = ~b[i]; #Q;
            scl_m = 1'b1;      #(2*Q);
            scl_m = 1'b0;      #Q;
        end
        sda_m_low = 1'b0; #Q;
        scl_m = 1'b1;     #Q;
        ack = sda_bus;    #Q;
        scl_m = 1'b0;     #Q;
    endtask

    task automatic m_recv(input logic nack, output logic [7:0] b);
        sda_m_low = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            #Q; scl_m = 1'b1;
            #Q; b[i] = sda_bus;
            #Q; scl_m = 1'b0;
        end
        #Q; sda_m_low = ~nack;
        #Q; scl_m = 1'b1;
        #(2*Q); scl_m = 1'b0;
        #Q; sda_m_low = 1'b0;
    endtask

    task automatic do_write(input logic [6:0] a, input logic [7:0] p,
                            input logic [7:0] d [8], input int n, output int nacks);
        logic ack;
        nacks = 0;
        m_start();
        m_send({a, 1'b0}, ack); nacks += int'(ack);
        m_send(p, ack);         nacks += int'(ack);
        for (int k = 0; k < n; k++) begin
            m_send(d[k], ack); nacks += int'(ack);
        end
        m_stop();
        repeat (10) @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        repeat (4) @(negedge clk);
        n_cmp++; if (regs0 !== '0) begin n_bad++; $display("FAIL reset_regs: got %h want 0", regs0); end
        n_cmp++; if ({busy0, wr0, rd0} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b want 000", {busy0, wr0, rd0}); end
        n_cmp++; if (acc0 !== 4'd0) begin n_bad++; $display("FAIL reset_acc: got %0d want 0", acc0); end
        n_cmp++; if (sda_bus !== 1'b1) begin n_bad++; $display("FAIL reset_sda: got %b want 1", sda_bus); end
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_burst_write();
        logic [7:0] d [8];
        int nk;
        d = '{8'hA5, 8'h5A, 0, 0, 0, 0, 0, 0};
        wr_q.delete();
        do_write(A0, 8'h03, d, 2, nk);
        model_write(3, d, 2);
        n_cmp++; if (nk !== 0) begin n_bad++; $display("FAIL burst_acks: got %0d nacks want 0", nk); end
        n_cmp++; if (regs0[8*3 +: 8] !== 8'hA5) begin n_bad++; $display("FAIL burst_reg3: got %h want a5", regs0[8*3 +: 8]); end
        n_cmp++; if (regs0[8*4 +: 8] !== 8'h5A) begin n_bad++; $display("FAIL burst_reg4: got %h want 5a", regs0[8*4 +: 8]); end
        n_cmp++; if (wr_q.size() !== 2) begin n_bad++; $display("FAIL burst_strobes: got %0d want 2", wr_q.size()); end
        else begin
            n_cmp++; if (wr_q[0] !== 4'd3 || wr_q[1] !== 4'd4) begin
                n_bad++; $display("FAIL burst_acc: got %0d,%0d want 3,4", wr_q[0], wr_q[1]);
            end
        end
        n_cmp++; if (busy0 !== 1'b0) begin n_bad++; $display("FAIL burst_busy: got %b want 0", busy0); end
    endtask

    task automatic test_wrap();
        logic [7:0] d [8];
        int nk;
        d = '{8'h11, 8'h22, 0, 0, 0, 0, 0, 0};
        do_write(A0, 8'h0F, d, 2, nk);
        model_write(15, d, 2);
        n_cmp++; if (nk !== 0) begin n_bad++; $display("FAIL wrap_acks: got %0d nacks want 0", nk); end
        n_cmp++; if (regs0[8*15 +: 8] !== 8'h11) begin n_bad++; $display("FAIL wrap_reg15: got %h want 11", regs0[8*15 +: 8]); end
        n_cmp++; if (regs0[7:0] !== 8'h22) begin n_bad++; $display("FAIL wrap_reg0: got %h want 22", regs0[7:0]); end
    endtask

    task automatic test_random_burst();
        logic [7:0] d [8];
        int nk, p, n;
        for (int it = 0; it < 5; it++) begin
            p = int'($urandom_range(0, NR - 1));
            n = int'($urandom_range(1, 8));
            for (int k = 0; k < 8; k++) d[k] = 8'($urandom);
            do_write(A0, 8'(p), d, n, nk);
            model_write(p, d, n);
            n_cmp++; if (nk !== 0) begin n_bad++; $display("FAIL rand_acks[%0d]: got %0d nacks want 0", it, nk); end
            n_cmp++; if (regs0 !== model_flat()) begin n_bad++; $display("FAIL rand_regs[%0d]: got %h want %h", it, regs0, model_flat()); end
        end
    endtask

    task automatic test_read_restart();
        logic a0, a1, a2;
        logic [7:0] b [3];
        rd_q.delete();
        m_start();
        m_send({A0, 1'b0}, a0);
        m_send(8'h02, a1);
        m_start();
        m_send({A0, 1'b1}, a2);
        m_recv(1'b0, b[0]);
        m_recv(1'b0, b[1]);
        m_recv(1'b1, b[2]);
        m_stop();
        repeat (10) @(negedge clk);
        n_cmp++; if ({a0, a1, a2} !== 3'b000) begin n_bad++; $display("FAIL rd_acks: got %b want 000", {a0, a1, a2}); end
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (b[k] !== mregs[2 + k]) begin n_bad++; $display("FAIL rd_byte[%0d]: got %h want %h", k, b[k], mregs[2 + k]); end
        end
        mptr = 5;
        n_cmp++; if (rd_q.size() !== 3) begin n_bad++; $display("FAIL rd_strobes: got %0d want 3", rd_q.size()); end
        else begin
            n_cmp++; if (rd_q[0] !== 4'd2 || rd_q[1] !== 4'd3 || rd_q[2] !== 4'd4) begin
                n_bad++; $display("FAIL rd_acc: got %0d,%0d,%0d want 2,3,4", rd_q[0], rd_q[1], rd_q[2]);
            end
        end
        n_cmp++; if ({busy0, sda_bus} !== 2'b01) begin n_bad++; $display("FAIL rd_end: got busy,sda=%b want 01", {busy0, sda_bus}); end
    endtask

    task automatic test_bad_ptr();
        logic a0, a1, a2;
        logic [7:0] b;
        m_start();
        m_send({A0, 1'b0}, a0);
        m_send(8'h20, a1);
        m_stop();
        repeat (10) @(negedge clk);
        n_cmp++; if ({a0, a1} !== 2'b01) begin n_bad++; $display("FAIL badptr_ack: got %b want 01", {a0, a1}); end
        m_start();
        m_send({A0, 1'b1}, a2);
        m_recv(1'b1, b);
        m_stop();
        repeat (10) @(negedge clk);
        n_cmp++; if (b !== mregs[mptr]) begin n_bad++; $display("FAIL badptr_read: got %h want %h", b, mregs[mptr]); end
        mptr = (mptr + 1) % NR;
    endtask

    task automatic test_other_addr();
        logic [7:0] d [8];
        logic [NR*8-1:0] snap;
        int nk, p;
        for (int k = 0; k < 8; k++) d[k] = 8'($urandom);
        do_write(7'h33, 8'h01, d, 1, nk);
        n_cmp++; if (nk !== 3) begin n_bad++; $display("FAIL noaddr_nacks: got %0d want 3", nk); end
        snap = regs0;
        busy_seen = 1'b0;
        p = int'($urandom_range(0, NR - 2));
        do_write(A1, 8'(p), d, 2, nk);
        n_cmp++; if (nk !== 0) begin n_bad++; $display("FAIL other_acks: got %0d nacks want 0", nk); end
        n_cmp++; if (busy_seen !== 1'b0) begin n_bad++; $display("FAIL other_busy0: got %b want 0", busy_seen); end
        n_cmp++; if (regs0 !== snap) begin n_bad++; $display("FAIL other_regs0: got %h want %h", regs0, snap); end
        n_cmp++; if (regs1[8*p +: 16] !== {d[1], d[0]}) begin n_bad++; $display("FAIL other_regs1: got %h want %h", regs1[8*p +: 16], {d[1], d[0]}); end
    endtask

    task automatic test_local_write();
        logic [7:0] d [8];
        logic a0, a1, a2;
        int p;
        logic seen;
        for (int it = 0; it < 3; it++) begin
            p = int'($urandom_range(0, NR - 1));
            @(negedge clk);
            loc_addr = 4'(p); loc_wdata = 8'($urandom); loc_we = 1'b1;
            mregs[p] = loc_wdata;
            @(negedge clk);
            loc_we = 1'b0;
            n_cmp++; if (regs0[8*p +: 8] !== mregs[p]) begin n_bad++; $display("FAIL local_wr[%0d]: got %h want %h", it, regs0[8*p +: 8], mregs[p]); end
        end
        // Collision: local port hammers the same index through the I2C byte.
        p = int'($urandom_range(0, NR - 1));
        d[0] = 8'($urandom);
        m_start();
        m_send({A0, 1'b0}, a0);
        m_send(8'(p), a1);
        loc_addr = 4'(p); loc_wdata = ~d[0]; loc_we = 1'b1;
        seen = 1'b0;
        fork
            m_send(d[0], a2);
            begin
                for (int c = 0; c < 400 && !seen; c++) begin
                    @(negedge clk);
                    if (wr0) seen = 1'b1;
                end
                loc_we = 1'b0;
            end
        join
        m_stop();
        repeat (10) @(negedge clk);
        model_write(p, d, 1);
        n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL coll_strobe: got %b want 1", seen); end
        n_cmp++; if (regs0[8*p +: 8] !== d[0]) begin n_bad++; $display("FAIL coll_wins: got %h want %h", regs0[8*p +: 8], d[0]); end
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] d [8];
        logic a0;
        int nk;
        @(negedge clk);
        loc_addr = 4'd6; loc_wdata = 8'h00; loc_we = 1'b1;
        @(negedge clk);
        loc_we = 1'b0;
        mregs[6] = 8'h00;
        do_write(A0, 8'h06, d, 0, nk);
        mptr = 6;
        m_start();
        m_send({A0, 1'b1}, a0);
        n_cmp++; if ({a0, sda_bus} !== 2'b00) begin n_bad++; $display("FAIL rst_pre: got ack,sda=%b want 00", {a0, sda_bus}); end
        reset_n = 1'b0;
        #1;
        n_cmp++; if (sda_bus !== 1'b1) begin n_bad++; $display("FAIL rst_sda: got %b want 1", sda_bus); end
        n_cmp++; if (regs0 !== '0 || busy0 !== 1'b0) begin n_bad++; $display("FAIL rst_state: got regs=%h busy=%b want 0", regs0, busy0); end
        scl_m = 1'b1;
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        model_clear();
        for (int k = 0; k < 8; k++) d[k] = 8'($urandom);
        do_write(A0, 8'h09, d, 3, nk);
        model_write(9, d, 3);
        n_cmp++; if (nk !== 0) begin n_bad++; $display("FAIL rst_after_acks: got %0d nacks want 0", nk); end
        n_cmp++; if (regs0 !== model_flat()) begin n_bad++; $display("FAIL rst_after_regs: got %h want %h", regs0, model_flat()); end
    endtask

    initial begin
        model_clear();
        busy_seen = 1'b0;
        test_reset();
        test_burst_write();
        test_wrap();
        test_random_burst();
        test_read_restart();
        test_bad_ptr();
        test_other_addr();
        test_local_write();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_i2c_slave_regfile
`default_nettype wire

// File: doc/i2c_slave_regfile.md
# i2c_slave_regfile

Parametrised I2C slave with an internal register bank, the next generation of the fixed single-byte `i2c_slave`. It decodes a 7-bit address set by parameter and keeps a register pointer that the master writes as the first byte. It auto-increments through `NUM_REGS` byte registers on burst writes and reads, wrapping at the end. It sits on the shared open-drain `scl`/`sda` bus beside other slaves and exposes the register bank and access strobes to local logic on `clk`.

## Interface
- `ADDRESS`, 7'h50: 7-bit I2C slave address.
- `NUM_REGS`, 16: number of 8-bit registers; power of two, 2..256.
- `PTR_W`, $clog2(NUM_REGS): register pointer width (derived; do not override).
- `clk`  input  1: system clock; must be at least 8x the SCL frequency.
- `reset_n`  input  1: asynchronous, active-low reset.
- `scl`  input  1: I2C clock (slave never stretches).
- `sda`  inout  1: I2C data, open-drain; driven only to 0, otherwise `z`.
- `loc_we`  input  1: local write enable.
- `loc_addr`  input  PTR_W: local write register index.
- `loc_wdata`  input  8: local write data.
- `regs`  output  NUM_REGS*8: register bank, flattened; reg i at [8i+7:8i].
- `wr_strobe`  output  1: one-cycle pulse when a byte is written from I2C.
- `rd_strobe`  output  1: one-cycle pulse when a register is loaded for transmission.
- `acc_addr`  output  PTR_W: register index for the current strobe.
- `busy`  output  1: high from own-address ACK until STOP, or until repeated START to another address.

## Operation
- `scl`/`sda` pass through a 2-FF synchroniser, then a previous-sample register. Rise, fall, START and STOP are decoded from the synchronised samples.
- START: `sda` falls while `scl` is high. Taken from any state; go to ADDR and clear the bit counter.
- STOP: `sda` rises while `scl` is high. Taken from any state; go to IDLE, release `sda`, drop `busy`.
- States and transitions:
  - IDLE: wait for START.
  - ADDR: shift 8 bits on `scl` rise.
    - Address match: go to ADDR_ACK.
    - Mismatch: go to IDLE.
  - ADDR_ACK: drive 0 for one SCL period. Then go to PTR if R/W=0. If R/W=1, go to RDATA.
  - PTR: receive the pointer byte.
    - Value < NUM_REGS: go to PTR_ACK and load the pointer.
    - Otherwise: NACK by releasing `sda`, go to IDLE, pointer unchanged.
  - PTR_ACK: ACK, then go to WDATA.
  - WDATA: receive a byte.
    - On the 8th rise, write regs[ptr], pulse `wr_strobe`, set `acc_addr`=ptr.
    - ptr <= (ptr+1) mod NUM_REGS.
    - Go to WDATA_ACK; ACK, then return to WDATA.
  - RDATA: on entry, load the shift register with regs[ptr] and pulse `rd_strobe`.
    - Drive MSB first; each bit changes after `scl` fall. A 1 bit releases `sda`.
    - Increment ptr after the 8th bit.
    - Go to RDATA_ACK; release `sda` and sample the master's bit on `scl` rise.
      - ACK (0): go to RDATA.
      - NACK (1): go to IDLE.
- Repeated START keeps the pointer. This enables write-pointer then restart-read.
- Local write updates regs[`loc_addr`] on the next `clk` edge. If the I2C write targets the same index in the same cycle, the I2C write wins.
- Reset values:
  - All regs 0, pointer 0, state IDLE.
  - `sda` released; `wr_strobe`, `rd_strobe`, `acc_addr`, `busy` all 0.
  - Reset mid-transfer releases `sda` immediately and asynchronously. The slave ignores the bus until the next START.

## Timing
- Pin-to-event latency: 3 `clk` cycles (2 sync + 1 edge detect).
- ACK or data drive changes within 1 `clk` after the detected `scl` fall, well inside SCL low at 8x oversampling. Never changes while `scl` is high, except on release at STOP or reset.
- `wr_strobe`: 1 `clk` after the detected 8th `scl` rise. `regs` are updated on the same edge.
- `rd_strobe`: the same cycle the shift register loads.
- `busy` rises with the ADDR_ACK entry. It falls 1 cycle after STOP is detected, or on a START whose address does not match.

## Structure
- Package `i2c_pkg`:
  - state enum `i2c_slv_state_t`
  - constants `I2C_RW_WRITE`=0 and `I2C_RW_READ`=1
  - `I2C_ACK`=0 and `I2C_NACK`=1
- Sub-module `i2c_line_sync`: synchroniser plus edge/START/STOP decode for the two lines. Outputs: `scl_rise`, `scl_fall`, `start_det`, `stop_det`, `sda_s`.

## Test plan
- Write 0x50 W, ptr 0x03, data 0xA5, 0x5A, STOP: ACK on all bytes; regs[3]=0xA5, regs[4]=0x5A; two `wr_strobe` pulses with `acc_addr` 3 then 4.
- Write ptr 0x0F, data 0x11, 0x22 (NUM_REGS=16): regs[15]=0x11, regs[0]=0x22 (wrap).
- Write ptr 0x02, repeated START, 0x50 R, read 3 bytes with ACK, ACK, NACK: master receives regs[2..4]; slave releases `sda` and returns to IDLE.
- Write ptr 0x20: NACK on the pointer byte; pointer unchanged; a following read returns the previous pointer's register.
- Address 0x51 transfer with a second instance at 0x51 and this one at 0x50: no `sda` drive and `busy`=0 on 0x50; only 0x51 ACKs.
- Assert `reset_n` low mid-RDATA while driving 0: `sda` goes `z` at once; all regs 0; a next full write transaction succeeds.
